// File: rtl/mem_port_arbiter.sv
// Two-master memory port arbiter: instruction fetch and data requests share one
// memory command port, one transaction in flight, with fetch anti-starvation and a WAIT timeout.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        bus_err,
   output logic        stall_if,
   output logic        stall_mem
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [3:0] STARVE_MAX   = 4'(STARVE_LIMIT);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        ownerData_q, ownerData_d;
   logic [3:0]  starveCnt_q, starveCnt_d;
   logic [7:0]  timeoutCnt_q, timeoutCnt_d;
   logic        mReq_q, mReq_d;
   logic        mWe_q, mWe_d;
   logic [31:0] mAddr_q, mAddr_d;
   logic [31:0] mWdata_q, mWdata_d;
   logic [3:0]  mWstrb_q, mWstrb_d;
   logic        ifValid_q, ifValid_d;
   logic        dValid_q, dValid_d;
   logic        busErr_q, busErr_d;
   logic [31:0] ifRdata_q, ifRdata_d;
   logic [31:0] dRdata_q, dRdata_d;
   logic        fetchWins;
   logic        respond;
   logic        respErr;
   logic [31:0] respData;

   always_comb begin
      state_d      = state_q;
      ownerData_d  = ownerData_q;
      starveCnt_d  = starveCnt_q;
      timeoutCnt_d = timeoutCnt_q;
      mReq_d       = mReq_q;
      mWe_d        = mWe_q;
      mAddr_d      = mAddr_q;
      mWdata_d     = mWdata_q;
      mWstrb_d     = mWstrb_q;
      ifValid_d    = 1'b0;
      dValid_d     = 1'b0;
      busErr_d     = 1'b0;
      ifRdata_d    = ifRdata_q;
      dRdata_d     = dRdata_q;
      respond      = 1'b0;
      respErr      = 1'b0;
      respData     = '0;
      // Data normally wins; a fetch that has waited out STARVE_LIMIT data grants takes the port.
      fetchWins    = if_req && (!d_req || (starveCnt_q == STARVE_MAX));

      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               mReq_d  = 1'b1;
               state_d = ISSUE;
               if (fetchWins) begin
                  ownerData_d = 1'b0;
                  mWe_d       = 1'b0;
                  mAddr_d     = if_addr;
                  mWdata_d    = '0;
                  mWstrb_d    = '0;
                  starveCnt_d = '0;
               end else begin
                  ownerData_d = 1'b1;
                  mWe_d       = d_we;
                  mAddr_d     = d_addr;
                  mWdata_d    = d_wdata;
                  mWstrb_d    = d_wstrb;
                  if (if_req && (starveCnt_q != STARVE_MAX)) begin
                     starveCnt_d = starveCnt_q + 4'd1;
                  end
               end
            end
         end
         ISSUE: begin
            if (m_gnt) begin
               mReq_d       = 1'b0;
               timeoutCnt_d = '0;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            if (m_rvalid) begin
               respond  = 1'b1;
               respData = mWe_q ? 32'd0 : m_rdata;
            end else if (timeoutCnt_q == TIMEOUT_LAST) begin
               respond = 1'b1;
               respErr = 1'b1;
            end else begin
               timeoutCnt_d = timeoutCnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (respond) begin
         state_d  = RESP;
         busErr_d = respErr;
         if (ownerData_q) begin
            dValid_d = 1'b1;
            dRdata_d = respData;
         end else begin
            ifValid_d = 1'b1;
            ifRdata_d = respData;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ownerData_q  <= 1'b0;
         starveCnt_q  <= '0;
         timeoutCnt_q <= '0;
         mReq_q       <= 1'b0;
         mWe_q        <= 1'b0;
         mAddr_q      <= '0;
         mWdata_q     <= '0;
         mWstrb_q     <= '0;
         ifValid_q    <= 1'b0;
         dValid_q     <= 1'b0;
         busErr_q     <= 1'b0;
         ifRdata_q    <= '0;
         dRdata_q     <= '0;
      end else begin
         state_q      <= state_d;
         ownerData_q  <= ownerData_d;
         starveCnt_q  <= starveCnt_d;
         timeoutCnt_q <= timeoutCnt_d;
         mReq_q       <= mReq_d;
         mWe_q        <= mWe_d;
         mAddr_q      <= mAddr_d;
         mWdata_q     <= mWdata_d;
         mWstrb_q     <= mWstrb_d;
         ifValid_q    <= ifValid_d;
         dValid_q     <= dValid_d;
         busErr_q     <= busErr_d;
         ifRdata_q    <= ifRdata_d;
         dRdata_q     <= dRdata_d;
      end
   end

   assign m_req     = mReq_q;
   assign m_we      = mWe_q;
   assign m_addr    = mAddr_q;
   assign m_wdata   = mWdata_q;
   assign m_wstrb   = mWstrb_q;
   assign if_valid  = ifValid_q;
   assign d_valid   = dValid_q;
   assign bus_err   = busErr_q;
   assign if_rdata  = ifRdata_q;
   assign d_rdata   = dRdata_q;
   assign stall_if  = if_req && !ifValid_q;
   assign stall_mem = d_req && !dValid_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request waits; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before an error completion; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  fetch read request; level, held until if_valid.
REQ-006 if_addr  input  32  fetch byte address; stable while if_req is high.
REQ-007 if_valid  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetch read data; valid with if_valid.
REQ-009 d_req  input  1  data request; level, held until d_valid.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_wstrb  input  4  store byte enables.
REQ-014 d_valid  output  1  one-cycle data completion pulse.
REQ-015 d_rdata  output  32  load data; valid with d_valid; 0 for stores.
REQ-016 m_req, m_we, m_addr[31:0], m_wdata[31:0], m_wstrb[3:0]  output  memory-port command, all registered.
REQ-017 m_gnt  input  1  memory accepts the command in the current cycle.
REQ-018 m_rvalid  input  1  memory completion; also the acknowledge for writes.
REQ-019 m_rdata  input  32  memory read data, qualified by m_rvalid.
REQ-020 bus_err  output  1  pulses with if_valid or d_valid on a timeout completion.
REQ-021 stall_if  output  1  if_req && !if_valid, combinational.
REQ-022 stall_mem  output  1  d_req && !d_valid, combinational.

Function
REQ-023 The FSM SHALL use the states IDLE, ISSUE, WAIT and RESP, with one transaction outstanding at a time.
REQ-024 IDLE, neither request: stay in IDLE.
REQ-025 IDLE, any request: the arbiter latches the winner's owner, we, addr, wdata and wstrb, then moves to ISSUE on the next edge.
REQ-026 Fetch-only commands SHALL be latched with we=0 and wstrb=0.
REQ-027 Arbitration: data wins, except when if_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch wins.
REQ-028 starve_cnt rules:
- increments on a data grant while if_req=1;
- clears on any fetch grant;
- holds otherwise;
- saturates at STARVE_LIMIT.
REQ-029 ISSUE: m_req=1 with the latched fields; on m_gnt=1, move to WAIT and clear the timeout counter; otherwise hold all m_* values unchanged.
REQ-030 WAIT: m_req=0; on m_rvalid=1, capture m_rdata (or 0 for a store) and move to RESP; otherwise increment the timeout counter.
REQ-031 WAIT timeout: when the counter reaches TIMEOUT without m_rvalid, move to RESP with rdata=0 and bus_err flagged.
REQ-032 RESP: assert exactly one of if_valid/d_valid (per owner) for one cycle, with rdata and bus_err; the requests are not sampled; return to IDLE.
REQ-033 Latency, zero-wait memory: request sampled in cycle N gives m_req in N+1; m_gnt in N+1 gives WAIT in N+2; m_rvalid in M≥N+2 gives valid in M+1; the next arbitration is at M+2.
REQ-034 Inactive cycles: m_gnt outside ISSUE and m_rvalid outside WAIT SHALL be ignored.
REQ-035 Request drops: a request dropped before being latched in IDLE is lost without side effects; once latched, the transaction completes even if the request is dropped.
REQ-036 Outside RESP, if_valid, d_valid, bus_err SHALL be 0, and if_rdata and d_rdata SHALL hold their last value.

Reset
REQ-037 Asserting rst SHALL immediately (asynchronously) force:
- state=IDLE;
- m_req=0, m_we=0, m_addr=0, m_wdata=0, m_wstrb=0;
- if_valid=0, d_valid=0, bus_err=0;
- if_rdata=0, d_rdata=0;
- starve_cnt=0 and timeout counter=0.
REQ-038 Reset mid-transaction SHALL discard the transaction without any completion pulse; a late m_rvalid after release is ignored per REQ-034.

Verification
REQ-039 Single load: d_req, d_addr=0x100, m_gnt immediate, m_rvalid one cycle later with m_rdata=0xDEADBEEF -> d_valid for 1 cycle, d_rdata=0xDEADBEEF, bus_err=0, latency per REQ-033.
REQ-040 Simultaneous requests: if_req and d_req both held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt returns to 0 after each F.
REQ-041 Backpressure: m_gnt held low for 5 cycles during a store (addr 0x200, wdata 0x12345678, wstrb 4'b0011) -> m_* values stable for all 6 ISSUE cycles; d_valid with d_rdata=0 after m_rvalid.
REQ-042 Timeout: TIMEOUT=8, m_rvalid never asserted -> d_valid and bus_err pulse together after 8 WAIT cycles, d_rdata=0; the next request is served normally.
REQ-043 Reset mid-WAIT: rst asserted during a fetch WAIT, then m_rvalid after release -> no if_valid, m_req=0, FSM in IDLE.
REQ-044 Stall outputs: if_req held high through a full fetch -> stall_if=1 every cycle except the if_valid cycle; stall_mem=0 throughout.
